lc_transition_requester: RTL and testbench
==========================================

Name: lc_transition_requester

Overview:
- Host-side initiator for the lifecycle transition/authentication protocol. The MCSE control unit is the responder on the other end of this interface.
- Accepts a transition command (target ID plus authentication ID) on a valid/ready port. Issues the transition request, answers the single authentication challenge, waits for completion and returns a status response.
- Adds a per-phase timeout with bounded retries. Drives the authentication secret onto the bus only in the one cycle it is presented, and scrubs it afterwards.

Parameters:
- ID_WIDTH, 256, width of transition ID and authentication ID.
- TIMEOUT_CYCLES, 1024, cycles allowed in each wait state before timeout (≥2).
- MAX_RETRIES, 2, re-issues allowed after a timeout before failing.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- host_req_valid  in  1  command valid.
- host_req_ready  out  1  high only in IDLE.
- host_transition_id  in  ID_WIDTH  requested transition ID.
- host_auth_id  in  ID_WIDTH  authentication ID (secret).
- host_resp_valid  out  1  response valid.
- host_resp_ready  in  1  response accepted.
- host_resp_success  out  1  lc_success captured at completion.
- host_resp_timeout  out  1  retries exhausted.
- host_resp_state  out  3  lc_state captured at completion.
- busy  out  1  high in any state other than IDLE.
- lc_transition_id  out  ID_WIDTH  latched transition ID.
- lc_transition_request_in  out  1  one-cycle request pulse.
- lc_authentication_id  out  ID_WIDTH  authentication ID; zero except in AUTH.
- lc_authentication_valid  out  1  one-cycle authentication strobe.
- lc_authentication_request  in  1  challenge from the responder.
- lc_done  in  1  transition complete.
- lc_success  in  1  valid with lc_done.
- lc_state  in  3  valid with lc_done.

Behaviour:
- Reset (rst=0 at a clk edge, any state):
  - State goes to IDLE.
  - All outputs 0 except host_req_ready=1.
  - Latched IDs, timer, retry count and captured status are cleared.
  - No request pulse is emitted during or after reset.
- States: IDLE, REQ, WAIT_AUTH, AUTH, WAIT_DONE, RESP.
- IDLE:
  - On host_req_valid&host_req_ready: latch both IDs, clear retry_cnt, go to REQ.
  - lc_* inputs are ignored.
- REQ (1 cycle):
  - lc_transition_request_in=1.
  - Clear timer, go to WAIT_AUTH.
  - lc_transition_id holds the latched value from REQ entry through RESP exit, then returns to 0.
- WAIT_AUTH (priority order):
  - lc_done: capture lc_success and lc_state, go to RESP. Covers a responder that rejects without issuing a challenge; lc_done wins over a simultaneous lc_authentication_request.
  - Else lc_authentication_request: go to AUTH.
  - Else timer==TIMEOUT_CYCLES-1: take the timeout path.
  - Else timer+1.
- AUTH (1 cycle):
  - lc_authentication_valid=1 and lc_authentication_id=latched auth ID.
  - Clear timer, go to WAIT_DONE.
- WAIT_DONE (priority order):
  - lc_done: capture, go to RESP. lc_done wins over a same-cycle timeout.
  - Else timeout on the same rule as WAIT_AUTH.
  - Any further lc_authentication_request is ignored; there is one challenge per attempt.
- Timeout path:
  - If retry_cnt<MAX_RETRIES: retry_cnt+1, go to REQ (new pulse).
  - Else: success=0, timeout=1, state=0, go to RESP.
- RESP:
  - host_resp_valid=1; fields held stable until host_resp_ready.
  - On handshake: go to IDLE, zero the latched auth ID and transition ID.
- Latency:
  - Command accept at cycle N gives the request pulse at N+1.
  - Challenge sampled at T gives the auth strobe at T+1.
  - lc_done sampled at T gives host_resp_valid at T+1.
- Timer width is $clog2(TIMEOUT_CYCLES) bits and never wraps. retry_cnt width is $clog2(MAX_RETRIES+1) bits.
- Response to a command arriving while busy: host_req_ready=0, so the command is not accepted.

Test Plan (bench TIMEOUT_CYCLES=16, MAX_RETRIES=2):
1. Happy path: issue transition_id=0x...A5, auth_id=0x...5A.
   - Responder challenges 3 cycles after the pulse and sets done=1, success=1, state=3'd4 two cycles after the auth strobe.
   - Expect exactly one request pulse and one auth strobe carrying 0x...5A, with lc_authentication_id=0 in all other cycles.
   - Expect response success=1, timeout=0, state=4.
2. Reject without challenge: lc_done=1, success=0, state=3'd2 arrives 5 cycles after the pulse.
   - Expect no auth strobe and response success=0, state=2.
3. Timeout and retry: responder never answers.
   - Expect 3 request pulses spaced 17 cycles apart (16 wait + 1 REQ).
   - Expect response timeout=1, success=0; latched IDs read 0 after the handshake.
4. Simultaneous events: lc_done and lc_authentication_request high in the same WAIT_AUTH cycle.
   - Expect RESP next cycle and no auth strobe.
   - Separately, lc_done on the timeout cycle of WAIT_DONE: expect success captured and no retry.
5. Backpressure and busy: hold host_resp_ready=0 for 10 cycles.
   - Expect response fields stable, host_req_valid ignored, busy=1.
   - Release: expect IDLE next cycle and host_req_ready=1.
6. Reset mid-operation: rst=0 in WAIT_DONE.
   - Expect all outputs zero and host_req_ready=1 the next cycle.
   - After release: no request pulse until a new command is accepted.

Source files
------------

// File: rtl/lc_transition_requester.sv
`default_nettype none
// ============================================================================
// Module      : lc_transition_requester
// Description : Host-side initiator for the lifecycle transition/authentication
//               handshake. Issues the request pulse, answers one challenge with
//               the authentication secret, waits for completion and returns a
//               status response. Each wait phase has a timeout and bounded
//               retries. The secret appears on the bus only in the AUTH cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module lc_transition_requester #(
    parameter int ID_WIDTH       = 256,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRIES    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                host_req_valid,
    output logic                host_req_ready,
    input  logic [ID_WIDTH-1:0] host_transition_id,
    input  logic [ID_WIDTH-1:0] host_auth_id,
    output logic                host_resp_valid,
    input  logic                host_resp_ready,
    output logic                host_resp_success,
    output logic                host_resp_timeout,
    output logic [2:0]          host_resp_state,
    output logic                busy,
    output logic [ID_WIDTH-1:0] lc_transition_id,
    output logic                lc_transition_request_in,
    output logic [ID_WIDTH-1:0] lc_authentication_id,
    output logic                lc_authentication_valid,
    input  logic                lc_authentication_request,
    input  logic                lc_done,
    input  logic                lc_success,
    input  logic [2:0]          lc_state
);

    localparam int c_TW = $clog2(TIMEOUT_CYCLES);
    localparam int c_RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_RW-1:0] c_RETRY_MAX  = c_RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT_AUTH = 3'd2,
        S_AUTH      = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_RESP      = 3'd5
    } state_t;

    state_t                r_state;
    logic [c_TW-1:0]       r_timer;
    logic [c_RW-1:0]       r_retry_cnt;
    logic [ID_WIDTH-1:0]   r_tid;
    logic [ID_WIDTH-1:0]   r_aid;
    logic [ID_WIDTH-1:0]   r_auth_id_out;
    logic                  r_req_ready;
    logic                  r_busy;
    logic                  r_req_pulse;
    logic                  r_auth_valid;
    logic                  r_resp_valid;
    logic                  r_resp_success;
    logic                  r_resp_timeout;
    logic [2:0]            r_resp_state;

    logic w_timer_last;
    logic w_retry_ok;

    // Timer expiry and retry budget decode
    assign w_timer_last = (r_timer == c_TIMER_LAST);
    assign w_retry_ok   = (r_retry_cnt < c_RETRY_MAX);

    // Protocol state machine; every output is a flop set on entry to its state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_retry_cnt    <= '0;
            r_tid          <= '0;
            r_aid          <= '0;
            r_auth_id_out  <= '0;
            r_req_ready    <= 1'b1;
            r_busy         <= 1'b0;
            r_req_pulse    <= 1'b0;
            r_auth_valid   <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_success <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_resp_state   <= 3'd0;
        end else begin
            // One-cycle strobes and the secret default low every cycle
            r_req_pulse   <= 1'b0;
            r_auth_valid  <= 1'b0;
            r_auth_id_out <= '0;
            case (r_state)
                S_IDLE: begin
                    if (host_req_valid) begin
                        r_tid       <= host_transition_id;
                        r_aid       <= host_auth_id;
                        r_retry_cnt <= '0;
                        r_req_pulse <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_AUTH;
                end
                S_WAIT_AUTH, S_WAIT_DONE: begin
                    if (lc_done) begin
                        // Completion beats a challenge or a timeout in the same cycle
                        r_resp_success <= lc_success;
                        r_resp_timeout <= 1'b0;
                        r_resp_state   <= lc_state;
                        r_resp_valid   <= 1'b1;
                        r_state        <= S_RESP;
                    end else if ((r_state == S_WAIT_AUTH) && lc_authentication_request) begin
                        // Only one challenge is answered per attempt
                        r_auth_valid  <= 1'b1;
                        r_auth_id_out <= r_aid;
                        r_state       <= S_AUTH;
                    end else if (w_timer_last) begin
                        if (w_retry_ok) begin
                            r_retry_cnt <= r_retry_cnt + 1'b1;
                            r_req_pulse <= 1'b1;
                            r_state     <= S_REQ;
                        end else begin
                            r_resp_success <= 1'b0;
                            r_resp_timeout <= 1'b1;
                            r_resp_state   <= 3'd0;
                            r_resp_valid   <= 1'b1;
                            r_state        <= S_RESP;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_AUTH: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_DONE;
                end
                S_RESP: begin
                    if (host_resp_ready) begin
                        // Scrub the latched IDs once the host has the status
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_tid        <= '0;
                        r_aid        <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign host_req_ready           = r_req_ready;
    assign busy                     = r_busy;
    assign host_resp_valid          = r_resp_valid;
    assign host_resp_success        = r_resp_success;
    assign host_resp_timeout        = r_resp_timeout;
    assign host_resp_state          = r_resp_state;
    assign lc_transition_id         = r_tid;
    assign lc_transition_request_in = r_req_pulse;
    assign lc_authentication_id     = r_auth_id_out;
    assign lc_authentication_valid  = r_auth_valid;

endmodule
`default_nettype wire

// File: tb/tb_lc_transition_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc_transition_requester
// Description : Directed bench for lc_transition_requester. Stimulus pushes the
//               expected response into a queue; a monitor pops and compares on
//               each response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc_transition_requester;

    localparam int IDW = 256;
    localparam int TO  = 16;
    localparam int MR  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           host_req_valid;
    logic           host_req_ready;
    logic [IDW-1:0] host_transition_id;
    logic [IDW-1:0] host_auth_id;
    logic           host_resp_valid;
    logic           host_resp_ready;
    logic           host_resp_success;
    logic           host_resp_timeout;
    logic [2:0]     host_resp_state;
    logic           busy;
    logic [IDW-1:0] lc_transition_id;
    logic           lc_transition_request_in;
    logic [IDW-1:0] lc_authentication_id;
    logic           lc_authentication_valid;
    logic           lc_authentication_request;
    logic           lc_done;
    logic           lc_success;
    logic [2:0]     lc_state;

    lc_transition_requester #(
        .ID_WIDTH      (IDW),
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .host_req_valid           (host_req_valid),
        .host_req_ready           (host_req_ready),
        .host_transition_id       (host_transition_id),
        .host_auth_id             (host_auth_id),
        .host_resp_valid          (host_resp_valid),
        .host_resp_ready          (host_resp_ready),
        .host_resp_success        (host_resp_success),
        .host_resp_timeout        (host_resp_timeout),
        .host_resp_state          (host_resp_state),
        .busy                     (busy),
        .lc_transition_id         (lc_transition_id),
        .lc_transition_request_in (lc_transition_request_in),
        .lc_authentication_id     (lc_authentication_id),
        .lc_authentication_valid  (lc_authentication_valid),
        .lc_authentication_request(lc_authentication_request),
        .lc_done                  (lc_done),
        .lc_success               (lc_success),
        .lc_state                 (lc_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_pulse = 0;
    int n_strobe = 0;
    int leak = 0;
    int pulse_cyc[$];
    logic [4:0] exp_q[$];
    logic [4:0] mon_exp;

    // Cycle counter used to time request pulses
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: count strobes, watch for secret leakage, score responses
    always @(negedge clk) begin
        if (lc_transition_request_in) begin
            n_pulse++;
            pulse_cyc.push_back(cyc);
        end
        if (lc_authentication_valid) n_strobe++;
        if (!lc_authentication_valid && lc_authentication_id != '0) leak++;
        if (host_resp_valid && host_resp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected actual={s,t,st}=%b required=none",
                         {host_resp_success, host_resp_timeout, host_resp_state});
            end else begin
                mon_exp = exp_q.pop_front();
                if ({host_resp_success, host_resp_timeout, host_resp_state} !== mon_exp) begin
                    errors++;
                    $display("FAIL resp_fields actual={s,t,st}=%b required=%b",
                             {host_resp_success, host_resp_timeout, host_resp_state}, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a command, wait (bounded) for acceptance; returns in the REQ cycle
    task automatic send_cmd(input logic [IDW-1:0] t, input logic [IDW-1:0] a);
        host_transition_id = t;
        host_auth_id       = a;
        host_req_valid     = 1'b1;
        for (int i = 0; i < 50 && !host_req_ready; i++) tick();
        chk("cmd_ready", host_req_ready, 1);
        tick();
        host_req_valid = 1'b0;
    endtask

    task automatic drive_done(input logic s, input logic [2:0] st);
        lc_done    = 1'b1;
        lc_success = s;
        lc_state   = st;
    endtask

    task automatic clear_lc();
        lc_done                   = 1'b0;
        lc_success                = 1'b0;
        lc_state                  = 3'd0;
        lc_authentication_request = 1'b0;
    endtask

    // Bounded wait for the DUT to return to idle
    task automatic settle();
        for (int i = 0; i < 200 && busy; i++) tick();
    endtask

    localparam logic [IDW-1:0] TID = {8{32'h1234_56A5}};
    localparam logic [IDW-1:0] AID = {8{32'h8765_435A}};

    int p0, s0, sz, bad_stable, bad_busy, bad_ready;
    logic [4:0] snap;

    initial begin
        rst = 1'b0;
        host_req_valid = 1'b0;
        host_transition_id = '0;
        host_auth_id = '0;
        host_resp_ready = 1'b1;
        clear_lc();
        ticks(3);
        chk("rst_req_ready", host_req_ready, 1);
        chk("rst_outs_zero", {host_resp_valid, host_resp_success, host_resp_timeout,
                              host_resp_state, busy, lc_transition_request_in,
                              lc_authentication_valid}, 0);
        chk("rst_no_pulse", n_pulse, 0);
        rst = 1'b1;
        ticks(2);

        // 1. Happy path
        p0 = n_pulse; s0 = n_strobe;
        send_cmd(TID, AID);
        chk("t1_tid_latched", lc_transition_id == TID, 1);
        ticks(3);
        lc_authentication_request = 1'b1;
        tick();
        lc_authentication_request = 1'b0;
        chk("t1_strobe", lc_authentication_valid, 1);
        chk("t1_auth_id", lc_authentication_id == AID, 1);
        ticks(2);
        drive_done(1'b1, 3'd4);
        exp_q.push_back({1'b1, 1'b0, 3'd4});
        tick();
        clear_lc();
        chk("t1_resp_valid", host_resp_valid, 1);
        tick();
        chk("t1_idle_ready", host_req_ready, 1);
        chk("t1_pulses", n_pulse - p0, 1);
        chk("t1_strobes", n_strobe - s0, 1);

        // 2. Reject without challenge
        p0 = n_pulse; s0 = n_strobe;
        send_cmd(TID, AID);
        ticks(5);
        drive_done(1'b0, 3'd2);
        exp_q.push_back({1'b0, 1'b0, 3'd2});
        tick();
        clear_lc();
        chk("t2_resp_valid", host_resp_valid, 1);
        tick();
        settle();
        chk("t2_no_strobe", n_strobe - s0, 0);

        // 3. Timeout with retries
        pulse_cyc.delete();
        p0 = n_pulse;
        send_cmd(TID, AID);
        exp_q.push_back({1'b0, 1'b1, 3'd0});
        for (int i = 0; i < 200 && !host_resp_valid; i++) tick();
        chk("t3_resp_valid", host_resp_valid, 1);
        chk("t3_pulses", n_pulse - p0, 3);
        sz = pulse_cyc.size();
        if (sz >= 3) begin
            chk("t3_gap1", pulse_cyc[sz-2] - pulse_cyc[sz-3], 17);
            chk("t3_gap2", pulse_cyc[sz-1] - pulse_cyc[sz-2], 17);
        end
        tick();
        settle();
        chk("t3_tid_zero", lc_transition_id == '0, 1);
        chk("t3_aid_zero", lc_authentication_id == '0, 1);

        // 4a. Done and challenge together in WAIT_AUTH
        s0 = n_strobe;
        send_cmd(TID, AID);
        ticks(2);
        drive_done(1'b1, 3'd5);
        lc_authentication_request = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 3'd5});
        tick();
        clear_lc();
        chk("t4a_resp_valid", host_resp_valid, 1);
        chk("t4a_no_strobe", lc_authentication_valid, 0);
        tick();
        settle();
        chk("t4a_strobes", n_strobe - s0, 0);

        // 4b. Done on the timeout cycle of WAIT_DONE
        p0 = n_pulse;
        send_cmd(TID, AID);
        tick();
        lc_authentication_request = 1'b1;
        tick();
        lc_authentication_request = 1'b0;
        tick();
        ticks(TO - 1);
        drive_done(1'b1, 3'd6);
        exp_q.push_back({1'b1, 1'b0, 3'd6});
        tick();
        clear_lc();
        chk("t4b_resp_valid", host_resp_valid, 1);
        tick();
        settle();
        chk("t4b_no_retry", n_pulse - p0, 1);

        // 5. Response backpressure while a new command waits
        host_resp_ready = 1'b0;
        send_cmd(TID, AID);
        ticks(2);
        drive_done(1'b1, 3'd3);
        exp_q.push_back({1'b1, 1'b0, 3'd3});
        tick();
        clear_lc();
        snap = {host_resp_success, host_resp_timeout, host_resp_state};
        p0 = n_pulse;
        bad_stable = 0; bad_busy = 0; bad_ready = 0;
        host_transition_id = ~TID;
        host_auth_id = ~AID;
        host_req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!host_resp_valid ||
                {host_resp_success, host_resp_timeout, host_resp_state} !== snap) bad_stable++;
            if (busy !== 1'b1) bad_busy++;
            if (host_req_ready !== 1'b0) bad_ready++;
            tick();
        end
        chk("t5_stable", bad_stable, 0);
        chk("t5_busy", bad_busy, 0);
        chk("t5_not_ready", bad_ready, 0);
        chk("t5_no_pulse", n_pulse - p0, 0);
        host_req_valid = 1'b0;
        host_resp_ready = 1'b1;
        tick();
        chk("t5_idle_ready", host_req_ready, 1);
        chk("t5_idle_busy", busy, 0);

        // 6. Reset while in WAIT_DONE
        send_cmd(TID, AID);
        tick();
        lc_authentication_request = 1'b1;
        tick();
        lc_authentication_request = 1'b0;
        ticks(3);
        rst = 1'b0;
        tick();
        chk("t6_req_ready", host_req_ready, 1);
        chk("t6_outs_zero", {host_resp_valid, host_resp_success, host_resp_timeout,
                             host_resp_state, busy, lc_transition_request_in,
                             lc_authentication_valid}, 0);
        chk("t6_ids_zero", (lc_transition_id == '0) && (lc_authentication_id == '0), 1);
        rst = 1'b1;
        p0 = n_pulse;
        ticks(5);
        chk("t6_no_pulse", n_pulse - p0, 0);
        send_cmd(TID, AID);
        chk("t6_new_pulse", lc_transition_request_in, 1);
        ticks(2);
        drive_done(1'b1, 3'd7);
        exp_q.push_back({1'b1, 1'b0, 3'd7});
        tick();
        clear_lc();
        tick();
        settle();

        chk("sb_drained", exp_q.size(), 0);
        chk("auth_id_leak", leak, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
